xor_check_arbiter: RTL and testbench

// Shares one registered XOR-parity checker (y = a ^ b, pass when y == 1) among NREQ requesters.

---
 rtl/xor_check_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_xor_check_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/xor_check_arbiter.sv
// xor_check_arbiter
//   One registered XOR-parity checker (pass when a ^ b == 1) shared by NREQ
//   requesters. Round-robin arbitration picks one operand pair, the check
//   runs, the result is reported, and failures are counted. The failure
//   count sets the report severity: INFO, WARN, ERROR, FATAL. FATAL halts
//   the block until reset.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous active-high reset
//   req       in   NREQ   per-requester check request (level)
//   a, b      in   NREQ   per-requester operands
//   gnt       out  NREQ   one-hot grant pulse; operands sampled this cycle
//   done      out  1      result-valid pulse
//   pass      out  1      last check result, valid with done and held after
//   gnt_id    out  3      requester index of the result, zero-extended
//   fail_cnt  out  CNT_W  saturating failed-check count
//   sev       out  2      0 INFO, 1 WARN, 2 ERROR, 3 FATAL
//   halt      out  1      sticky once sev reaches FATAL
//
// Thresholds must satisfy FAIL_WARN < FAIL_ERR < FAIL_FATAL <= 2**CNT_W-1.
// ASSERT_EN gates the simulation-only severity report.
module xor_check_arbiter #(
  parameter int NREQ       = 4,
  parameter int CNT_W      = 8,
  parameter int FAIL_WARN  = 2,
  parameter int FAIL_ERR   = 4,
  parameter int FAIL_FATAL = 8,
  parameter bit ASSERT_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  a,
  input  logic [NREQ-1:0]  b,
  output logic [NREQ-1:0]  gnt,
  output logic             done,
  output logic             pass,
  output logic [2:0]       gnt_id,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [1:0]       sev,
  output logic             halt
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] SEV_INFO  = 2'd0;
  localparam logic [1:0] SEV_WARN  = 2'd1;
  localparam logic [1:0] SEV_ERR   = 2'd2;
  localparam logic [1:0] SEV_FATAL = 2'd3;

  typedef enum logic [1:0] {IDLE, GRANT, REPORT, HALT} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             a_q, a_d, b_q, b_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sev_q, sev_d;
  logic             halt_q, halt_d;

  logic             res;
  logic [CNT_W-1:0] cnt_new;
  logic [1:0]       sev_new;

  // First set request at or after ptr, wrapping. Only called with |r.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [IDW-1:0]  ptr);
    logic [IDW-1:0] sel;
    logic           hit;
    int             j;
    sel = '0;
    hit = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!hit && r[j]) begin
        hit = 1'b1;
        sel = IDW'(j);
      end
    end
    return sel;
  endfunction

  // Result of the check in flight and the counter/severity it would produce.
  always_comb begin
    res     = a_q ^ b_q;
    cnt_new = (res || (&cnt_q)) ? cnt_q : cnt_q + CNT_W'(1);
    if      (int'(cnt_new) >= FAIL_FATAL) sev_new = SEV_FATAL;
    else if (int'(cnt_new) >= FAIL_ERR)   sev_new = SEV_ERR;
    else if (int'(cnt_new) >= FAIL_WARN)  sev_new = SEV_WARN;
    else                                  sev_new = SEV_INFO;
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    gnt_d   = '0;
    a_d     = a_q;
    b_d     = b_q;
    pass_d  = pass_q;
    cnt_d   = cnt_q;
    sev_d   = sev_q;
    halt_d  = halt_q;
    unique case (state_q)
      IDLE: begin
        // Arbitration is decided on the IDLE->GRANT edge, so a grant is
        // never issued for a request that vanished before that edge.
        if (|req) begin
          id_d    = rr_pick(req, rr_q);
          gnt_d   = NREQ'(1) << id_d;
          state_d = GRANT;
        end
      end
      GRANT: begin
        a_d     = a[id_q];
        b_d     = b[id_q];
        state_d = REPORT;
      end
      REPORT: begin
        pass_d = res;
        rr_d   = (int'(id_q) == NREQ - 1) ? '0 : id_q + IDW'(1);
        cnt_d  = cnt_new;
        sev_d  = sev_new;
        if (sev_new == SEV_FATAL) begin
          halt_d  = 1'b1;
          state_d = HALT;
        end else begin
          state_d = IDLE;
        end
      end
      HALT: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      pass_q  <= 1'b0;
      cnt_q   <= '0;
      sev_q   <= SEV_INFO;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
      sev_q   <= sev_d;
      halt_q  <= halt_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = (state_q == REPORT);
  // Live result during REPORT, the stored one afterwards.
  assign pass     = (state_q == REPORT) ? res : pass_q;
  assign gnt_id   = 3'(id_q);
  assign fail_cnt = cnt_q;
  assign sev      = sev_q;
  assign halt     = halt_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (ASSERT_EN && !rst && state_q == REPORT) begin
      assert (res) else begin
        case (sev_new)
          SEV_INFO: $info("xor check failed: gnt_id=%0d fail_cnt=%0d", id_q, cnt_new);
          SEV_WARN: $warning("xor check failed: gnt_id=%0d fail_cnt=%0d", id_q, cnt_new);
          SEV_ERR:  $error("xor check failed: gnt_id=%0d fail_cnt=%0d", id_q, cnt_new);
          default:  $fatal(1, "xor check failed: gnt_id=%0d fail_cnt=%0d", id_q, cnt_new);
        endcase
      end
    end
  end
`endif

endmodule

// File: tb/tb_xor_check_arbiter.sv
module tb_xor_check_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, a, b;

  logic [3:0] gnt0, gnt1;
  logic       done0, done1, pass0, pass1, halt0, halt1;
  logic [2:0] gid0, gid1;
  logic [7:0] cnt0;
  logic [2:0] cnt1;
  logic [1:0] sev0, sev1;

  always #5 clk = ~clk;

  // Instance 0: default sizing. Instance 1: 3-bit counter that saturates
  // exactly at its FATAL threshold. Both see the same requesters.
  xor_check_arbiter #(.NREQ(4), .CNT_W(8), .FAIL_WARN(2), .FAIL_ERR(4),
                      .FAIL_FATAL(8), .ASSERT_EN(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .gnt(gnt0), .done(done0),
    .pass(pass0), .gnt_id(gid0), .fail_cnt(cnt0), .sev(sev0), .halt(halt0));

  xor_check_arbiter #(.NREQ(4), .CNT_W(3), .FAIL_WARN(2), .FAIL_ERR(3),
                      .FAIL_FATAL(7), .ASSERT_EN(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .gnt(gnt1), .done(done1),
    .pass(pass1), .gnt_id(gid1), .fail_cnt(cnt1), .sev(sev1), .halt(halt1));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: per instance, round-robin pointer, failure count,
  // halted flag and last reported result.
  localparam int MAXC[2]  = '{255, 7};
  localparam int WARN[2]  = '{2, 2};
  localparam int ERRT[2]  = '{4, 3};
  localparam int FATAL[2] = '{8, 7};

  int m_rr[2], m_cnt[2];
  bit m_halt[2], m_pass[2];

  logic [3:0] o_gnt[2];
  logic       o_done[2], o_pass[2], o_halt[2];
  logic [2:0] o_gid[2];
  logic [7:0] o_cnt[2];
  logic [1:0] o_sev[2];

  task automatic sample();
    o_gnt[0] = gnt0;  o_gnt[1] = gnt1;
    o_done[0] = done0; o_done[1] = done1;
    o_pass[0] = pass0; o_pass[1] = pass1;
    o_halt[0] = halt0; o_halt[1] = halt1;
    o_gid[0] = gid0;  o_gid[1] = gid1;
    o_cnt[0] = cnt0;  o_cnt[1] = {5'd0, cnt1};
    o_sev[0] = sev0;  o_sev[1] = sev1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sev_of(input int k, input int c);
    if (c >= FATAL[k]) return 3;
    if (c >= ERRT[k])  return 2;
    if (c >= WARN[k])  return 1;
    return 0;
  endfunction

  function automatic int pick(input logic [3:0] r, input int rr);
    for (int k = 0; k < 4; k++)
      if (r[(rr + k) % 4]) return (rr + k) % 4;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_rr[k] = 0; m_cnt[k] = 0; m_halt[k] = 1'b0; m_pass[k] = 1'b0;
    end
  endtask

  task automatic chk_status(input string tag);
    sample();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_cnt%0d", tag, k), o_cnt[k], m_cnt[k]);
      chk($sformatf("%s_sev%0d", tag, k), o_sev[k], sev_of(k, m_cnt[k]));
      chk($sformatf("%s_halt%0d", tag, k), o_halt[k], m_halt[k]);
      chk($sformatf("%s_pass%0d", tag, k), o_pass[k], m_pass[k]);
      chk($sformatf("%s_done%0d", tag, k), o_done[k], 0);
    end
  endtask

  // Entered and left on a negedge with both FSMs idle or halted.
  task automatic do_reset();
    rst = 1'b1; req = '0;
    @(negedge clk);
    model_reset();
    sample();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_gnt%0d", k), o_gnt[k], 0);
      chk($sformatf("rst_gid%0d", k), o_gid[k], 0);
    end
    chk_status("rst");
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One full check: request at this negedge, grant next cycle, result the
  // cycle after, status the cycle after that.
  task automatic do_check(input logic [3:0] r, input logic [3:0] av,
                          input logic [3:0] bv, input bit drop_in_grant);
    int sel[2];
    bit act[2], exp_p[2];
    req = r; a = av; b = bv;
    for (int k = 0; k < 2; k++) begin
      act[k]   = !m_halt[k];
      sel[k]   = pick(r, m_rr[k]);
      exp_p[k] = av[sel[k]] ^ bv[sel[k]];
    end
    @(posedge clk); @(negedge clk);
    sample();
    for (int k = 0; k < 2; k++)
      chk($sformatf("gnt%0d", k), o_gnt[k], act[k] ? (32'd1 << sel[k]) : 32'd0);
    if (drop_in_grant) req = '0;
    @(posedge clk); @(negedge clk);
    req = '0;
    sample();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("done%0d", k), o_done[k], act[k]);
      if (act[k]) begin
        chk($sformatf("pass%0d", k), o_pass[k], exp_p[k]);
        chk($sformatf("gid%0d", k), o_gid[k], sel[k]);
        if (!exp_p[k] && m_cnt[k] < MAXC[k]) m_cnt[k]++;
        m_rr[k]   = (sel[k] + 1) % 4;
        m_pass[k] = exp_p[k];
        if (sev_of(k, m_cnt[k]) == 3) m_halt[k] = 1'b1;
      end
    end
    @(posedge clk); @(negedge clk);
    chk_status("post");
  endtask

  initial begin
    rst = 1'b1; req = '0; a = '0; b = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single passing check on requester 0.
    do_check(4'b0001, 4'b0001, 4'b0000, 1'b0);

    // All four requesting, failing operands: strict rotation.
    repeat (5) do_check(4'b1111, 4'b0000, 4'b0000, 1'b0);

    // Two failures on requester 2 reach WARN.
    do_reset();
    repeat (2) do_check(4'b0100, 4'b0100, 4'b0100, 1'b0);

    // Request that vanishes before the arbitration edge: no grant.
    req = 4'b0010; #2 req = '0;
    @(posedge clk); @(negedge clk);
    sample();
    chk("vanish_gnt0", o_gnt[0], 0);
    chk("vanish_gnt1", o_gnt[1], 0);
    @(posedge clk); @(negedge clk);
    chk_status("vanish");

    // Reset in the GRANT cycle of a failing check.
    do_reset();
    req = 4'b0100; a = 4'b1111; b = 4'b1111;
    @(posedge clk); @(negedge clk);
    sample();
    chk("g_before_rst", o_gnt[0], 4'b0100);
    rst = 1'b1; req = '0;
    #1 sample();
    chk("g_async_rst", o_gnt[0], 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk); @(negedge clk);
    chk_status("after_rst");
    do_check(4'b0010, 4'b0010, 4'b0000, 1'b0);

    // Granted requester drops during GRANT: check still completes.
    do_check(4'b1000, 4'b0000, 4'b0000, 1'b1);

    // Run to FATAL on both instances; instance 1 saturates and halts at 7.
    do_reset();
    repeat (8) do_check(4'b0001, 4'b0000, 4'b0000, 1'b0);
    req = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); @(negedge clk);
      sample();
      chk("halt_gnt0", o_gnt[0], 0);
      chk("halt_gnt1", o_gnt[1], 0);
      chk("halt_done0", o_done[0], 0);
    end
    chk_status("halted");
    do_reset();

    // Randomized checks against the model; reset whenever instance 0 halts.
    for (int i = 0; i < 60; i++) begin
      logic [3:0] r, av, bv;
      bit         drop;
      r    = 4'($urandom_range(1, 15));
      av   = 4'($urandom);
      bv   = 4'($urandom);
      drop = ($urandom_range(0, 3) == 0);
      do_check(r, av, bv, drop);
      if (m_halt[0]) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
